// File: rtl/systolic_feeder.sv
// West/north edge feeder for an N x N output-stationary systolic array:
// captures both operands, clears the PEs, streams skewed operands, then pulses done.
module systolic_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [N*N*DATA_WIDTH-1:0]    a_flat_i,
  input  logic [N*N*DATA_WIDTH-1:0]    b_flat_i,
  output logic [N*DATA_WIDTH-1:0]      left_o,
  output logic [N*DATA_WIDTH-1:0]      up_o,
  output logic                         pe_rst_no,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int LAST_STEP = 3 * N - 3;
  localparam int STEP_W    = $clog2(LAST_STEP + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} state_t;

  state_t                      state_reg, state_next;
  logic [STEP_W-1:0]           step_reg, step_next;
  logic                        capture;
  logic [N*N*DATA_WIDTH-1:0]   a_reg, b_reg;
  logic [N*DATA_WIDTH-1:0]     left_next, up_next;
  logic                        pe_rst_next, busy_next, done_next;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      step_reg  <= '0;
      left_o    <= '0;
      up_o      <= '0;
      pe_rst_no <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      left_o    <= left_next;
      up_o      <= up_next;
      pe_rst_no <= pe_rst_next;
      busy_o    <= busy_next;
      done_o    <= done_next;
    end
  end

  // Operand copy is pure datapath; it is only consulted after a capture.
  always_ff @(posedge clk_i) begin
    if (capture) begin
      a_reg <= a_flat_i;
      b_reg <= b_flat_i;
    end
  end

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          state_next = CLEAR;
          step_next  = '0;
          capture    = 1'b1;
        end
      end
      CLEAR: begin
        state_next = FEED;
        step_next  = '0;
      end
      FEED: begin
        if (step_reg == STEP_W'(LAST_STEP)) begin
          state_next = DONE;
          step_next  = '0;
        end else begin
          step_next = step_reg + STEP_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        step_next  = '0;
      end
    endcase
  end

  // Outputs are registered, so they are derived from the state being entered.
  always_comb begin
    pe_rst_next = (state_next != CLEAR);
    busy_next   = (state_next != IDLE);
    done_next   = (state_next == DONE);
    left_next   = '0;
    up_next     = '0;
    if (state_next == FEED) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(step_next) == i + k)
            left_next[i*DATA_WIDTH +: DATA_WIDTH] = a_reg[(i*N+k)*DATA_WIDTH +: DATA_WIDTH];
          if (int'(step_next) == k + i)
            up_next[i*DATA_WIDTH +: DATA_WIDTH] = b_reg[(k*N+i)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Drives the west and north edges of an N×N output-stationary systolic multiply array. It captures two N×N operand matrices on a start request and clears the array's accumulators. It then streams the operands in diagonal-skewed order so that PE(i,j) sees A[i][k] and B[k][j] together. It signals completion once the last product has been accumulated, so the array's result registers can be read.

## Interface
- DATA_WIDTH, 32, width of one matrix element
- N, 4, array dimension (N ≥ 2)

- clk_i  input  1  clock; all state changes on rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- start_i  input  1  start request; sampled only in IDLE
- a_flat_i  input  N*N*DATA_WIDTH  matrix A; A[i][k] at bits [(i*N+k)*DATA_WIDTH +: DATA_WIDTH]
- b_flat_i  input  N*N*DATA_WIDTH  matrix B; B[k][j] at bits [(k*N+j)*DATA_WIDTH +: DATA_WIDTH]
- left_o  output  N*DATA_WIDTH  west-edge feed; row i at [i*DATA_WIDTH +: DATA_WIDTH]
- up_o  output  N*DATA_WIDTH  north-edge feed; column j at [j*DATA_WIDTH +: DATA_WIDTH]
- pe_rst_no  output  1  active-low clear to every PE reset input
- busy_o  output  1  high from the CLEAR cycle through the DONE cycle
- done_o  output  1  one-cycle pulse; array results valid and stable

## Operation
- All outputs are registered. Reset values:
  - left_o = 0, up_o = 0
  - pe_rst_no = 0, so the array is held clear during reset
  - busy_o = 0, done_o = 0
  - state = IDLE, step counter = 0
- States: IDLE → CLEAR → FEED → DONE → IDLE.
- IDLE:
  - Outputs are zero and pe_rst_no = 1.
  - start_i = 1 captures a_flat_i and b_flat_i into internal operand registers and moves to CLEAR.
- CLEAR: lasts exactly one cycle.
  - pe_rst_no = 0, feeds are zero, busy_o = 1.
  - Next state is FEED with step t = 0.
- FEED: step t runs from 0 to 3N-3, one cycle per step, with pe_rst_no = 1.
  - left_o row i = A[i][t-i] when 0 ≤ t-i ≤ N-1, else 0.
  - up_o column j = B[t-j][j] when 0 ≤ t-j ≤ N-1, else 0.
  - Last nonzero feed is at t = 2N-2. Steps 2N-1..3N-3 feed zeros so the in-array pass-through registers can drain.
  - After step 3N-3 the next state is DONE.
- DONE: lasts one cycle.
  - done_o = 1, busy_o = 1, feeds zero.
  - Next state is IDLE.
- Operand registers are read only from the captured copy. Changes on a_flat_i/b_flat_i after the start cycle have no effect.
- start_i outside IDLE is ignored and is not queued. start_i during DONE is also ignored.
- The block does not read results. Results stay stable after DONE because the array only receives zeros (0×0 accumulate) until the next CLEAR.

## Timing
- Cycle 0: start_i high in IDLE.
- Cycle 1: CLEAR (pe_rst_no low).
- Cycles 2 .. 3N-1: FEED steps t = 0 .. 3N-3.
- Cycle 3N: done_o high.
- Cycle 3N+1: IDLE, earliest cycle a new start_i is accepted.
- For N = 4: done_o in cycle 12; start-to-start period is 13 cycles.
- The PE (i,j) operand alignment relies on the array's one-cycle right/down forwarding: PE(i,j) receives A[i][k] and B[k][j] in step k+i+j.
- Reset asserted mid-operation:
  - Immediate return to IDLE, with all outputs at reset values and pe_rst_no low while reset is held.
  - No done_o pulse is produced for the aborted run.
- pe_rst_no comes straight from a flop (glitch-free). It is safe as an asynchronous PE reset.

## Test plan
- N=4, A = identity, B[k][j] = 10k+j, start in cycle 0 → pe_rst_no low only in cycle 1; done_o high only in cycle 12; array results equal B; busy_o high cycles 1–12.
- Skew check with the same run → at step t=1: left_o rows = {A[0][1], A[1][0], 0, 0}; at t=6: only row 3 / column 3 nonzero (A[3][3], B[3][3]); t=7..9: all feeds zero.
- start_i held high continuously → runs back-to-back: second CLEAR in cycle 14, second done_o in cycle 25; no start captured during DONE.
- start_i pulse at cycle 5 during a run, and a_flat_i changed at cycle 3 → ignored; feeds still use values captured at cycle 0; done_o still in cycle 12.
- rst_ni low in cycle 6 (mid-FEED) → outputs zero and pe_rst_no low asynchronously; no done_o; after release, IDLE; a new start completes normally 12 cycles later.
- All elements = 2^DATA_WIDTH-1 → feeds carry full-scale values unmodified; result PE(0,0) = 4·(2^DATA_WIDTH-1)² modulo 2^(2·DATA_WIDTH).
